// File: rtl/serial_out_sequencer.sv
// Command FIFO and launch sequencer feeding diff_freq_serial_out.
// Optional inter-packet gap state enabled by defining SEQ_GAP_EN.
module serial_out_sequencer #(
    parameter int unsigned DATA_BIT   = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_BIT   = 3,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [DATA_BIT-1:0] i_wr_data,
    input  logic                i_wr_freq,
    input  logic [1:0]          i_wr_idle,
    input  logic                i_enable,
    input  logic                i_abort,
    input  logic                i_done_tick,
    output logic                o_start,
    output logic                o_stop,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_sel_freq,
    output logic [1:0]          o_idle_mode,
    output logic                o_full,
    output logic                o_empty,
    output logic [ADDR_BIT:0]   o_count,
    output logic                o_busy,
    output logic                o_overflow,
    output logic                o_drained
);

    localparam int unsigned ENTRY_BIT = DATA_BIT + 3;

    if (DEPTH != (1 << ADDR_BIT) || DEPTH < 2 || GAP_CYCLES < 1) begin : g_bad_param
        $error("serial_out_sequencer: invalid parameter set");
    end

`ifdef SEQ_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP} state_t;
    logic [GAP_W-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;
`endif

    state_t               state, state_next;
    logic [ENTRY_BIT-1:0] mem [DEPTH];
    logic [ADDR_BIT-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_BIT:0]    count;
    logic                 full, empty, push, pop, drain_set;

    assign full  = (count == (ADDR_BIT+1)'(DEPTH));
    assign empty = (count == '0);
    // Fullness is judged before the same-clock pop, so a push into a full FIFO is lost even in LOAD.
    assign push  = i_wr_en && !full && !i_abort;
    assign pop   = (state == LOAD) && !i_abort;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_wr_idle, i_wr_freq, i_wr_data};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else if (i_abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_BIT'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_BIT'(1);
            if (push && !pop)      count <= count + (ADDR_BIT+1)'(1);
            else if (!push && pop) count <= count - (ADDR_BIT+1)'(1);
            if (i_wr_en && full) o_overflow <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        drain_set  = 1'b0;
        case (state)
            IDLE:  if (i_enable && !empty) state_next = LOAD;
            LOAD:  state_next = START;
            START: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (i_done_tick) begin
`ifdef SEQ_GAP_EN
                    state_next = GAP;
`else
                    if (i_enable && !empty) state_next = LOAD;
                    else begin
                        state_next = IDLE;
                        drain_set  = empty;
                    end
`endif
                end
            end
`ifdef SEQ_GAP_EN
            GAP: begin
                if (gap_cnt == '0) begin
                    if (i_enable && !empty) state_next = LOAD;
                    else begin
                        state_next = IDLE;
                        drain_set  = empty;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (i_abort) begin
            state_next = IDLE;
            drain_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            o_stop      <= 1'b0;
            o_drained   <= 1'b0;
            o_data      <= '0;
            o_sel_freq  <= 1'b0;
            o_idle_mode <= 2'b00;
        end else begin
            state     <= state_next;
            o_stop    <= i_abort;
            o_drained <= drain_set;
            if (pop) {o_idle_mode, o_sel_freq, o_data} <= mem[rd_ptr];
        end
    end

`ifdef SEQ_GAP_EN
    // Counter is preloaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES clocks.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) gap_cnt <= '0;
        else if (state_next == GAP && state != GAP) gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
    end
`endif

    assign o_start = (state == START);
    assign o_busy  = (state != IDLE);
    assign o_full  = full;
    assign o_empty = empty;
    assign o_count = count;

endmodule

// File: tb/tb_serial_out_sequencer.sv
// Directed bench for serial_out_sequencer with a command scoreboard and a
// serializer stand-in that ticks done 16 clocks after each start.
module tb_serial_out_sequencer;

    localparam int DB    = 8;
    localparam int DEPTH = 8;
    localparam int AB    = 3;
`ifdef SEQ_GAP_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [DB-1:0] i_wr_data = '0;
    logic          i_wr_freq = 1'b0;
    logic [1:0]    i_wr_idle = 2'b00;
    logic          i_enable = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_done_tick = 1'b0;
    logic          o_start, o_stop, o_sel_freq, o_full, o_empty, o_busy, o_overflow, o_drained;
    logic [DB-1:0] o_data;
    logic [1:0]    o_idle_mode;
    logic [AB:0]   o_count;

    serial_out_sequencer #(.DATA_BIT(DB), .DEPTH(DEPTH), .ADDR_BIT(AB), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .i_wr_freq(i_wr_freq), .i_wr_idle(i_wr_idle), .i_enable(i_enable),
        .i_abort(i_abort), .i_done_tick(i_done_tick), .o_start(o_start), .o_stop(o_stop),
        .o_data(o_data), .o_sel_freq(o_sel_freq), .o_idle_mode(o_idle_mode),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_busy(o_busy),
        .o_overflow(o_overflow), .o_drained(o_drained)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_count = 0, stop_count = 0, drained_count = 0;
    int last_start = 0, last_drained = 0;
    int done_cnt = 0;
    logic [DB+2:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Serializer stand-in: done tick driven 16 clocks after each observed start.
    always @(negedge clk) begin
        i_done_tick = 1'b0;
        if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) i_done_tick = 1'b1;
        end
        if (o_start === 1'b1) done_cnt = 16;
    end

    always @(negedge clk) begin
        if (o_start === 1'b1) begin
            start_count++;
            last_start = cyc;
            if (sb.size() == 0) check("start_unexpected", 32'd1, 32'd0);
            else check("start_fields", {o_idle_mode, o_sel_freq, o_data}, sb.pop_front());
        end
        if (o_stop === 1'b1) stop_count++;
        if (o_drained === 1'b1) begin
            drained_count++;
            last_drained = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [DB-1:0] d, input logic f, input logic [1:0] m, input bit kept);
        i_wr_en = 1'b1; i_wr_data = d; i_wr_freq = f; i_wr_idle = m;
        if (kept) sb.push_back({m, f, d});
        step();
        i_wr_en = 1'b0;
    endtask

    task automatic wait_start(input int target, input int budget, input string tag);
        int n = 0;
        while (start_count < target && n < budget) begin step(); n++; end
        check(tag, 32'(start_count >= target), 32'd1);
    endtask

    task automatic wait_drain(input int target, input int budget, input string tag);
        int n = 0;
        while (drained_count < target && n < budget) begin step(); n++; end
        check(tag, 32'(drained_count >= target), 32'd1);
    endtask

    initial begin
        int s0, d0, st0, pc, t1;
        repeat (3) step();
        check("reset_ctrl", {o_start, o_stop, o_full, o_busy, o_overflow, o_drained}, 0);
        check("reset_fields", {o_idle_mode, o_sel_freq, o_data}, 0);
        check("reset_empty", o_empty, 1);
        check("reset_count", o_count, 0);
        rst_n = 1'b0;
        step();

        // Reset while a packet is in flight with 3 more queued
        s0 = start_count;
        push(8'h11, 1'b0, 2'b01, 1'b1);
        push(8'h22, 1'b1, 2'b10, 1'b1);
        push(8'h33, 1'b0, 2'b11, 1'b1);
        push(8'h44, 1'b1, 2'b00, 1'b1);
        i_enable = 1'b1;
        wait_start(s0 + 1, 10, "t1_start_timeout");
        repeat (4) step();
        check("t1_pre_count", o_count, 3);
        check("t1_pre_busy", o_busy, 1);
        rst_n = 1'b1;
        #2;
        check("t1_rst_ctrl", {o_start, o_stop, o_full, o_busy, o_overflow, o_drained}, 0);
        check("t1_rst_fields", {o_idle_mode, o_sel_freq, o_data}, 0);
        check("t1_rst_empty", o_empty, 1);
        check("t1_rst_count", o_count, 0);
        sb.delete();
        step();
        step();
        rst_n = 1'b0;
        repeat (25) step();

        // Single packet: latency, fields, drained pulse
        s0 = start_count; d0 = drained_count;
        pc = cyc;
        push(8'h55, 1'b1, 2'b00, 1'b1);
        wait_start(s0 + 1, 10, "t2_start_timeout");
        check("t2_start_latency", 32'(last_start - pc), 3);
        wait_drain(d0 + 1, 40, "t2_drain_timeout");
        check("t2_drain_delay", 32'(last_drained - last_start), 32'(17 + GAP));
        check("t2_busy_after", o_busy, 0);
        step();
        check("t2_drained_pulse", o_drained, 0);
        check("t2_start_once", 32'(start_count - s0), 1);

        // Three back-to-back packets
        s0 = start_count; d0 = drained_count;
        push(8'h55, 1'b1, 2'b00, 1'b1);
        push(8'hAA, 1'b0, 2'b01, 1'b1);
        push(8'h0F, 1'b0, 2'b10, 1'b1);
        wait_start(s0 + 1, 10, "t3_start1_timeout");
        t1 = last_start;
        wait_start(s0 + 2, 40, "t3_start2_timeout");
        check("t3_spacing_1_2", 32'(last_start - t1), 32'(18 + GAP));
        t1 = last_start;
        wait_start(s0 + 3, 40, "t3_start3_timeout");
        check("t3_spacing_2_3", 32'(last_start - t1), 32'(18 + GAP));
        wait_drain(d0 + 1, 40, "t3_drain_timeout");
        repeat (5) step();
        check("t3_drained_once", 32'(drained_count - d0), 1);
        check("t3_sb_empty", 32'(sb.size()), 0);

        // Fill with launches disabled, overflow on the 9th push
        i_enable = 1'b0;
        s0 = start_count;
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i), i[0], 2'(i), 1'b1);
        check("t4_full", o_full, 1);
        check("t4_count8", o_count, 8);
        check("t4_no_ovf_yet", o_overflow, 0);
        push(8'hFF, 1'b1, 2'b11, 1'b0);
        check("t4_overflow", o_overflow, 1);
        check("t4_count_held", o_count, 8);
        repeat (5) step();
        check("t4_no_start", 32'(start_count - s0), 0);

        // Abort from IDLE flushes and clears overflow
        st0 = stop_count;
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        sb.delete();
        check("t4_abort_stop", o_stop, 1);
        check("t4_abort_count", o_count, 0);
        check("t4_abort_ovf_clr", o_overflow, 0);
        step();
        check("t4_stop_single", 32'(stop_count - st0), 1);

        // Push into full FIFO in the LOAD clock
        s0 = start_count; d0 = drained_count;
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i), ~i[0], 2'(3 - i % 4), 1'b1);
        check("t6_full", o_full, 1);
        i_enable = 1'b1;
        step();
        check("t6_in_load_busy", o_busy, 1);
        push(8'hEE, 1'b1, 2'b01, 1'b0);
        check("t6_overflow", o_overflow, 1);
        check("t6_count", o_count, 7);
        wait_start(s0 + 8, 8 * (20 + GAP), "t6_starts_timeout");
        wait_drain(d0 + 1, 40, "t6_drain_timeout");
        check("t6_sb_empty", 32'(sb.size()), 0);

        // Abort in WAIT_DONE with 4 queued, push during abort clock
        i_enable = 1'b0;
        s0 = start_count; d0 = drained_count; st0 = stop_count;
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), i[0], 2'b10, 1'b1);
        i_enable = 1'b1;
        wait_start(s0 + 1, 10, "t5_start_timeout");
        repeat (3) step();
        check("t5_pre_count", o_count, 4);
        i_abort = 1'b1;
        i_wr_en = 1'b1; i_wr_data = 8'h99;
        step();
        i_abort = 1'b0; i_wr_en = 1'b0;
        sb.delete();
        check("t5_stop", o_stop, 1);
        check("t5_count", o_count, 0);
        check("t5_busy", o_busy, 0);
        check("t5_fields_kept", {o_idle_mode, o_sel_freq, o_data}, {2'b10, 1'b0, 8'hC0});
        step();
        check("t5_stop_pulse", o_stop, 0);
        repeat (30) step();
        check("t5_no_start", 32'(start_count - s0), 1);
        check("t5_no_drained", 32'(drained_count - d0), 0);
        check("t5_stop_once", 32'(stop_count - st0), 1);
        check("t5_idle", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
